// File: rtl/microcode_sequencer_if.sv
// ROM fetch port and datapath issue/status port of the microcode sequencer.
// Latency: none (wires only); ROM_data is expected the cycle after ROM_readEnable.
// Backpressure: datapath applies dp_ready against dp_valid; ROM port has no backpressure.
interface microcode_sequencer_if #(
  parameter int ROM_addressBits = 6,
  parameter int RF_addressBits  = 3
);
  localparam int W = 5 + 2*RF_addressBits;

  logic                       ROM_readEnable;
  logic [ROM_addressBits-1:0] ROM_address;
  logic [W-1:0]               ROM_data;
  logic                       dp_valid;
  logic                       dp_ready;
  logic [3:0]                 dp_opcode;
  logic [RF_addressBits-1:0]  dp_rd;
  logic [RF_addressBits-1:0]  dp_rs;
  logic                       zero_flag;
  logic                       neg_flag;

  // Sequencer side.
  modport master (
    output ROM_readEnable, ROM_address, dp_valid, dp_opcode, dp_rd, dp_rs,
    input  ROM_data, dp_ready, zero_flag, neg_flag
  );

  // ROM / datapath side.
  modport slave (
    input  ROM_readEnable, ROM_address, dp_valid, dp_opcode, dp_rd, dp_rs,
    output ROM_data, dp_ready, zero_flag, neg_flag
  );
endinterface

// File: rtl/microcode_sequencer.sv
// Fetches, decodes and executes microcode words; issues ALU ops and resolves branches.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXECUTE) plus dp_ready stall cycles.
// Backpressure: an ALU op holds EXECUTE with stable dp_* fields until dp_valid & dp_ready.
module microcode_sequencer #(
  parameter int ROM_addressBits = 6,
  parameter int RF_addressBits  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  microcode_sequencer_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal_op
);
  localparam int W = 5 + 2*RF_addressBits;
  localparam logic [ROM_addressBits-1:0] PC_ONE = 1;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_JZ   = 4'd9;
  localparam logic [3:0] OP_JN   = 4'd10;
  localparam logic [3:0] OP_HALT = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_HALT
  } state_t;

  state_t                     state, state_nxt;
  logic [ROM_addressBits-1:0] pc, pc_nxt;
  logic [W-1:0]               ir;
  logic                       ir_load;

  logic [3:0]                 ir_opc;
  logic [RF_addressBits-1:0]  ir_rd;
  logic [RF_addressBits-1:0]  ir_rs;
  logic [ROM_addressBits-1:0] ir_target;
  logic [ROM_addressBits-1:0] pc_inc;

  assign ir_opc    = ir[W-1:W-4];
  assign ir_rd     = ir[2*RF_addressBits:RF_addressBits+1];
  assign ir_rs     = ir[RF_addressBits:1];
  assign ir_target = ir[ROM_addressBits-1:0];
  assign pc_inc    = pc + PC_ONE;

  logic                      rd_en;
  logic                      dp_vld;
  logic [3:0]                dp_opc;
  logic [RF_addressBits-1:0] dp_rd_q;
  logic [RF_addressBits-1:0] dp_rs_q;

  assign bus.ROM_readEnable = rd_en;
  assign bus.ROM_address    = pc;
  assign bus.dp_valid       = dp_vld;
  assign bus.dp_opcode      = dp_opc;
  assign bus.dp_rd          = dp_rd_q;
  assign bus.dp_rs          = dp_rs_q;

  // State, program counter and instruction register; reset aborts any operation at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (ir_load) ir <= bus.ROM_data;
    end
  end

  // Next-state, next-pc and all outputs decoded from the current state and instruction.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ir_load    = 1'b0;
    rd_en      = 1'b0;
    dp_vld     = 1'b0;
    dp_opc     = 4'd0;
    dp_rd_q    = '0;
    dp_rs_q    = '0;
    busy       = 1'b0;
    done       = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          pc_nxt    = '0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        busy      = 1'b1;
        rd_en     = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        busy      = 1'b1;
        ir_load   = 1'b1;
        state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        busy = 1'b1;
        if (ir_opc >= 4'd1 && ir_opc <= 4'd7) begin
          // ALU op: fields come straight from the IR, so they stay stable while stalled.
          dp_vld  = 1'b1;
          dp_opc  = ir_opc;
          dp_rd_q = ir_rd;
          dp_rs_q = ir_rs;
          if (bus.dp_ready) begin
            pc_nxt    = pc_inc;
            state_nxt = S_FETCH;
          end
        end else begin
          state_nxt = S_FETCH;
          case (ir_opc)
            OP_NOP:  pc_nxt = pc_inc;
            OP_JMP:  pc_nxt = ir_target;
            OP_JZ:   pc_nxt = bus.zero_flag ? ir_target : pc_inc;
            OP_JN:   pc_nxt = bus.neg_flag  ? ir_target : pc_inc;
            OP_HALT: state_nxt = S_HALT;
            default: begin
              // Reserved opcodes behave as NOP but are flagged.
              pc_nxt     = pc_inc;
              illegal_op = 1'b1;
            end
          endcase
        end
      end
      S_HALT: begin
        done = 1'b1;
        if (start) begin
          pc_nxt    = '0;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_microcode_sequencer.sv
module tb_microcode_sequencer;
  localparam int AB = 6;
  localparam int RB = 3;
  localparam int W  = 5 + 2*RB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, illegal_op;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_ill   = 0;

  logic [AB-1:0] fetch_q[$];
  logic [9:0]    op_q[$];
  logic [W-1:0]  rom[64];

  always #5 clk = ~clk;

  microcode_sequencer_if #(.ROM_addressBits(AB), .RF_addressBits(RB)) bus();

  microcode_sequencer #(.ROM_addressBits(AB), .RF_addressBits(RB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .illegal_op(illegal_op)
  );

  // Synchronous ROM: data valid the cycle after the read strobe.
  always @(posedge clk) if (bus.ROM_readEnable) bus.ROM_data <= rom[bus.ROM_address];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int op, input int rd, input int rs);
    logic [3:0] o; logic [2:0] d; logic [2:0] s;
    o = op[3:0]; d = rd[2:0]; s = rs[2:0];
    return {o, d, s, 1'b0};
  endfunction

  function automatic logic [W-1:0] mkj(input int op, input int tgt);
    logic [3:0] o; logic [5:0] t;
    o = op[3:0]; t = tgt[5:0];
    return {o, 1'b0, t};
  endfunction

  // Monitor: scoreboard pops on fetches and accepted ALU ops, plus per-cycle invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ROM_readEnable) begin
        if (fetch_q.size() > 0) chk("fetch_addr", 32'(bus.ROM_address), 32'(fetch_q.pop_front()));
        else chk("fetch_unexpected", 32'(fetch_q.size()), 32'd1);
      end
      if (bus.dp_valid) begin
        n_valid++;
        if (bus.dp_ready) begin
          if (op_q.size() > 0)
            chk("dp_op", 32'({bus.dp_opcode, bus.dp_rd, bus.dp_rs}), 32'(op_q.pop_front()));
          else chk("dp_unexpected", 32'(op_q.size()), 32'd1);
        end
      end else begin
        chk("dp_idle_zero", 32'({bus.dp_opcode, bus.dp_rd, bus.dp_rs}), 32'd0);
      end
      if (illegal_op) n_ill++;
      chk("busy_done_excl", 32'(busy & done), 32'd0);
    end
  end

  task automatic run_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !bus.dp_valid; i++) @(negedge clk);
    chk("valid_reached", 32'(bus.dp_valid), 32'd1);
  endtask

  task automatic end_test(input string tag);
    for (int i = 0; i < 300 && !done; i++) @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_fetch_q"}, 32'(fetch_q.size()), 32'd0);
    chk({tag, "_op_q"}, 32'(op_q.size()), 32'd0);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = mkj(11, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] alu_op;
    int br_op[4], br_z[4], br_n[4], br_nxt[4];
    alu_op = {4'd3, 3'd5, 3'd2};
    br_op  = '{9, 9, 10, 10};
    br_z   = '{1, 0, 0, 1};
    br_n   = '{0, 1, 1, 0};
    br_nxt = '{20, 1, 20, 1};

    bus.dp_ready = 1'b1; bus.zero_flag = 1'b0; bus.neg_flag = 1'b0;
    clear_rom();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", 32'(bus.ROM_readEnable), 0);
    chk("rst_addr", 32'(bus.ROM_address), 0);
    chk("rst_valid", 32'(bus.dp_valid), 0);
    chk("rst_opcode", 32'(bus.dp_opcode), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ill", 32'(illegal_op), 0);
    rst_n = 1'b1;

    // HALT at address 0, cycle-by-cycle.
    fetch_q.push_back(6'd0);
    run_start();
    @(negedge clk);
    chk("halt_c1_rd_en", 32'(bus.ROM_readEnable), 1);
    chk("halt_c1_addr", 32'(bus.ROM_address), 0);
    chk("halt_c1_busy", 32'(busy), 1);
    @(negedge clk);
    chk("halt_c2_rd_en", 32'(bus.ROM_readEnable), 0);
    @(negedge clk);
    chk("halt_c3_done", 32'(done), 0);
    @(negedge clk);
    chk("halt_c4_done", 32'(done), 1);
    chk("halt_c4_busy", 32'(busy), 0);
    end_test("halt");

    // Single ALU op, no stall.
    rom[0] = mk(3, 5, 2); rom[1] = mkj(11, 0);
    n_valid = 0;
    fetch_q.push_back(6'd0); fetch_q.push_back(6'd1); op_q.push_back(alu_op);
    run_start();
    end_test("alu");
    chk("alu_valid_cycles", 32'(n_valid), 1);

    // Same op with 4 cycles of dp_ready low.
    bus.dp_ready = 1'b0;
    n_valid = 0;
    fetch_q.push_back(6'd0); fetch_q.push_back(6'd1); op_q.push_back(alu_op);
    run_start();
    wait_valid();
    for (int k = 0; k < 4; k++) begin
      chk("stall_valid", 32'(bus.dp_valid), 1);
      chk("stall_fields", 32'({bus.dp_opcode, bus.dp_rd, bus.dp_rs}), 32'(alu_op));
      chk("stall_rd_en", 32'(bus.ROM_readEnable), 0);
      if (k < 3) @(negedge clk);
    end
    @(posedge clk); #1 bus.dp_ready = 1'b1;
    end_test("stall");
    chk("stall_valid_cycles", 32'(n_valid), 5);

    // Conditional branches, taken and not taken.
    for (int t = 0; t < 4; t++) begin
      clear_rom();
      rom[0] = mkj(br_op[t], 20);
      bus.zero_flag = br_z[t][0]; bus.neg_flag = br_n[t][0];
      fetch_q.push_back(6'd0); fetch_q.push_back(br_nxt[t][5:0]);
      run_start();
      end_test("branch");
    end
    bus.zero_flag = 1'b0; bus.neg_flag = 1'b0;

    // JMP 62 -> reserved op 14 -> NOP at 63 -> wrap to 0 (rewritten to HALT).
    clear_rom();
    rom[0] = mkj(8, 62); rom[62] = mk(14, 0, 0); rom[63] = mk(0, 0, 0);
    n_ill = 0;
    fetch_q.push_back(6'd0); fetch_q.push_back(6'd62);
    fetch_q.push_back(6'd63); fetch_q.push_back(6'd0);
    run_start();
    @(posedge clk); #1 rom[0] = mkj(11, 0);
    end_test("wrap");
    chk("illegal_pulses", 32'(n_ill), 1);

    // Reset during an EXECUTE stall.
    clear_rom();
    rom[0] = mk(3, 5, 2);
    bus.dp_ready = 1'b0;
    fetch_q.push_back(6'd0);
    run_start();
    wait_valid();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.dp_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_addr", 32'(bus.ROM_address), 0);
    chk("arst_fetch_q", 32'(fetch_q.size()), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Restart from IDLE; start pulsed mid-stall must not disturb pc.
    fetch_q.push_back(6'd0); fetch_q.push_back(6'd1); op_q.push_back(alu_op);
    run_start();
    wait_valid();
    run_start();
    bus.dp_ready = 1'b1;
    end_test("restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Control unit that fetches microcode words from the synchronous microcode ROM and decodes them.
- Issues register-file/ALU operations to the datapath with a valid/ready handshake.
- Resolves jumps and conditional branches on datapath status flags.
- Sits between the ROM and the datapath; owns the program counter and the run/halt state of the processor.

Parameters:
- ROM_addressBits, 6, ROM address width; program counter width. Must satisfy ROM_addressBits <= 2*RF_addressBits+1.
- RF_addressBits, 3, register-file address width. Instruction word width W = 5+2*RF_addressBits (11 at defaults).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin execution at address 0; sampled in IDLE and HALT only.
- ROM_readEnable  out  1  ROM read strobe.
- ROM_address  out  ROM_addressBits  fetch address (equals pc).
- ROM_data  in  W  instruction word, valid the cycle after ROM_readEnable.
- dp_valid  out  1  datapath operation valid.
- dp_ready  in  1  datapath accepts the operation.
- dp_opcode  out  4  ALU opcode (1..7).
- dp_rd  out  RF_addressBits  destination register.
- dp_rs  out  RF_addressBits  source register.
- zero_flag  in  1  datapath result zero.
- neg_flag  in  1  datapath result negative.
- busy  out  1  high in FETCH/DECODE/EXECUTE.
- done  out  1  high while in HALT.
- illegal_op  out  1  one-cycle pulse on a reserved opcode.

Behaviour:
- Word fields:
  - opcode = ROM_data[W-1:W-4]
  - rd = [2*RF_addressBits:RF_addressBits+1]
  - rs = [RF_addressBits:1]
  - bit 0 is reserved and ignored.
  - Jump target = ROM_data[ROM_addressBits-1:0].
- Opcodes:
  - 0 NOP
  - 1-7 ALU ops, passed through as dp_opcode
  - 8 JMP
  - 9 JZ
  - 10 JN
  - 11 HALT
  - 12-15 reserved: execute as NOP and pulse illegal_op in EXECUTE.
- Reset: state=IDLE, pc=0, instruction register=0. All outputs are 0, including ROM_address=0 and ROM_readEnable=0. Reset mid-operation aborts immediately; dp_valid drops asynchronously.
- States: IDLE, FETCH, DECODE, EXECUTE, HALT.
  - IDLE: start=1 -> FETCH with pc=0.
  - FETCH: ROM_readEnable=1, ROM_address=pc, for exactly one cycle -> DECODE.
  - DECODE: ROM_readEnable=0; latch ROM_data into the instruction register -> EXECUTE.
  - EXECUTE, ALU op: dp_valid=1 with dp_opcode/dp_rd/dp_rs held stable until dp_valid&dp_ready. On that cycle pc<=pc+1 -> FETCH. dp_ready low stalls indefinitely; the outputs must not change while stalled.
  - EXECUTE, NOP/reserved: one cycle, pc<=pc+1 -> FETCH.
  - EXECUTE, JMP: pc<=target -> FETCH.
  - EXECUTE, JZ/JN: sample zero_flag/neg_flag in the EXECUTE cycle. Taken: pc<=target. Not taken: pc<=pc+1. Then -> FETCH.
  - EXECUTE, HALT: pc unchanged -> HALT.
  - HALT: done=1. start=1 -> pc=0, FETCH.
- start is ignored in FETCH, DECODE and EXECUTE.
- Latency: 3 cycles minimum per instruction (FETCH, DECODE, EXECUTE), plus dp_ready stall cycles.
- pc increments modulo 2^ROM_addressBits: 63+1 wraps to 0 at defaults.
- dp_opcode/dp_rd/dp_rs are 0 whenever dp_valid=0.
- busy and done are mutually exclusive; both are 0 in IDLE.

Test Plan:
- Reset then start pulse; ROM[0]=HALT (opcode 11) -> ROM_readEnable high cycle 1, ROM_address=0; done=1 from cycle 4; busy=0 in HALT.
- ROM[0]=ALU op 3, rd=5, rs=2; ROM[1]=HALT; dp_ready tied 1 -> dp_valid pulse of exactly one cycle with dp_opcode=3, dp_rd=5, dp_rs=2; next fetch address=1.
- Same program with dp_ready held 0 for 4 cycles -> dp_valid high 5 cycles with stable fields; ROM_readEnable stays 0 until the handshake completes.
- ROM[0]=JZ target 20; ROM[20]=HALT. zero_flag=1 -> next ROM_address=20. Repeat with zero_flag=0 -> next ROM_address=1. Repeat with JN/neg_flag.
- ROM[63]=NOP, reached via JMP 63 -> next ROM_address=0 (wrap); opcode 14 -> illegal_op pulses exactly one cycle and pc advances by 1.
- rst_n asserted low during an EXECUTE stall -> dp_valid=0 immediately, busy=0, state IDLE; after release, start re-fetches address 0. start pulsed while busy -> no effect on pc.
